mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//   Iterative RV32M multiply/divide unit downstream of src_b_mux. It consumes alu_src_a and alu_src_b
//   (rs2 or imm selected by src_b_mux) in parallel with the ALU. It runs a radix-2 shift-add /
//   restoring-divide sequence over 32 cycles and returns a 32-bit result with a one-cycle done pulse.
//   The controller stalls the pipeline while busy=1.
// PARAMETERS
//   XLEN     32  operand/result width; only 32 is supported
//   CNT_W    6   iteration counter width; must be >= log2(XLEN)+1
// PORTS
//   clk      in   1      core clock; everything is updated on its rising edge
//   rst      in   1      synchronous reset, active-high
//   start    in   1      request; sampled only in IDLE
//   op       in   `SEL_MULDIV_WIDTH   MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   src_a    in   32     operand A (rs1 data)
//   src_b    in   32     operand B (alu_src_b from src_b_mux)
//   busy     out  1      1 from the cycle after start is accepted until done is asserted
//   done     out  1      one-cycle pulse; result is valid in this cycle
//   result   out  32     final value; held until the next accepted start
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, result=0; counter, accumulators and latched operands cleared.
//     A reset in CALC or FIN aborts the operation at the next edge; no done pulse is produced.
//   States and transitions:
//     IDLE: start=1 latches op, src_a, src_b, |a|, |b| and the result sign.
//       Normal case -> CALC with counter=0.
//       Special-case divide -> FIN directly.
//     CALC: one iteration per cycle. At counter=XLEN-1 -> FIN. start is ignored.
//     FIN: apply sign fixup and register result; done=1 for this cycle only; busy=0.
//       Next state is always IDLE.
//   Latency: start at edge N -> busy=1 from N+1 -> done=1 in the cycle after edge N+33 (34 cycles).
//     Special-case divides: done in the cycle after edge N+1.
//     start in the done cycle is ignored; the earliest re-issue is the following cycle (IDLE).
//   Multiply: 64-bit unsigned product of the magnitudes, negated when the result sign=1.
//     MUL returns bits[31:0]; MULH, MULHSU and MULHU return bits[63:32].
//     MULHSU: only src_a is treated as signed.
//   Divide: restoring shift-subtract on the magnitudes.
//     Quotient sign = sign_a ^ sign_b. Remainder sign = sign_a.
//   Special cases (RISC-V spec values, no trap):
//     Divide by zero: DIV/DIVU -> 32'hFFFF_FFFF; REM/REMU -> src_a.
//     Signed overflow, src_a=32'h8000_0000 and src_b=32'hFFFF_FFFF:
//       DIV -> 32'h8000_0000; REM -> 0.
//   Width rules: the accumulator is 2*XLEN wide; remainder compare/subtract is XLEN+1 wide.
//     There is no truncation before FIN.
//   Inputs src_a, src_b and op may change after the accept edge; only the latched copies are used.
// CONFIGURATION
//   MULDIV_DIV_EN defined: all eight ops are implemented as above.
//   MULDIV_DIV_EN undefined:
//     DIV, DIVU, REM and REMU go IDLE->FIN with result=0 (done after 1 cycle).
//     Divider datapath and special-case logic are removed; multiply timing is unchanged.
// STRUCTURE
//   param_mul_div.vh holds:
//     `SEL_MULDIV_WIDTH (3) and the op encodings `MULDIV_MUL..`MULDIV_REMU (0..7).
//     The state encodings.
//   Sub-module muldiv_sign_adj (combinational) computes:
//     operand magnitudes, result sign, and final negate/select.
//   The FSM, counter and accumulators stay in mul_div_unit.
// TESTING
//   1 MUL a=7, b=-3 (32'hFFFF_FFFD) -> done after 34 cycles, result=32'hFFFF_FFEB; busy=1 throughout.
//   2 MULH a=b=32'h8000_0000 -> 32'h4000_0000.
//     MULHU a=b=32'hFFFF_FFFF -> 32'hFFFF_FFFE.
//     MULHSU a=-1, b=2 -> 32'hFFFF_FFFF.
//   3 DIV a=-20, b=3 -> 32'hFFFF_FFFA (-6). REM -> 32'hFFFF_FFFE (-2). DIVU a=20, b=3 -> 6.
//   4 DIVU a=5, b=0 -> 32'hFFFF_FFFF. REMU a=5, b=0 -> 5.
//     DIV a=32'h8000_0000, b=-1 -> 32'h8000_0000.
//     All three: done one cycle after start.
//   5 Assert rst at CALC counter=10 -> next cycle busy=0, done=0, result=0.
//     No done pulse follows. A new MUL 3*4 then returns 12.
//   6 Pulse start with a new op at CALC counter=5 -> ignored; the first result is unchanged.
//     Build without MULDIV_DIV_EN: DIV 20/3 -> result=0 after 1 cycle.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - op select width, op encodings and FSM states for mul_div_unit
package mul_div_unit_pkg;

  localparam int SEL_MULDIV_WIDTH = 3;

  typedef enum logic [SEL_MULDIV_WIDTH-1:0] {
    MULDIV_MUL    = 3'd0,
    MULDIV_MULH   = 3'd1,
    MULDIV_MULHSU = 3'd2,
    MULDIV_MULHU  = 3'd3,
    MULDIV_DIV    = 3'd4,
    MULDIV_DIVU   = 3'd5,
    MULDIV_REM    = 3'd6,
    MULDIV_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } muldiv_state_e;

  // Divide ops occupy the upper half of the encoding space.
  function automatic logic is_div_op(input logic [SEL_MULDIV_WIDTH-1:0] op);
    return op[SEL_MULDIV_WIDTH-1];
  endfunction

endpackage

// File: rtl/muldiv_sign_adj.sv
// rtl/muldiv_sign_adj.sv - operand magnitudes, result sign and final negate/select
// Divide result selection exists only when MULDIV_DIV_EN is defined.
module muldiv_sign_adj
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [SEL_MULDIV_WIDTH-1:0] op_in,
  input  logic [XLEN-1:0]             src_a,
  input  logic [XLEN-1:0]             src_b,
  output logic [XLEN-1:0]             mag_a,
  output logic [XLEN-1:0]             mag_b,
  output logic                        res_neg,
  input  logic [SEL_MULDIV_WIDTH-1:0] op_fin,
  input  logic                        neg_fin,
  input  logic [2*XLEN-1:0]           acc,
  output logic [XLEN-1:0]             fin_value
);

  muldiv_op_e     op_in_e;
  muldiv_op_e     op_fin_e;
  logic           a_signed;
  logic           b_signed;
  logic           sign_a;
  logic           sign_b;
  logic [2*XLEN-1:0] prod;
`ifdef MULDIV_DIV_EN
  logic [XLEN-1:0] div_sel;
`endif

  always_comb begin
    op_in_e  = muldiv_op_e'(op_in);
    a_signed = op_in_e inside {MULDIV_MUL, MULDIV_MULH, MULDIV_MULHSU, MULDIV_DIV, MULDIV_REM};
    b_signed = op_in_e inside {MULDIV_MUL, MULDIV_MULH, MULDIV_DIV, MULDIV_REM};
    sign_a   = a_signed & src_a[XLEN-1];
    sign_b   = b_signed & src_b[XLEN-1];
    mag_a    = sign_a ? -src_a : src_a;
    mag_b    = sign_b ? -src_b : src_b;
    // A remainder takes the dividend's sign; everything else takes the xor.
    res_neg  = (op_in_e == MULDIV_REM) ? sign_a : (sign_a ^ sign_b);
  end

  always_comb begin
    op_fin_e  = muldiv_op_e'(op_fin);
    prod      = neg_fin ? -acc : acc;
    fin_value = '0;
`ifdef MULDIV_DIV_EN
    div_sel   = '0;
`endif
    if (!is_div_op(op_fin)) begin
      fin_value = (op_fin_e == MULDIV_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else begin
`ifdef MULDIV_DIV_EN
      div_sel   = (op_fin_e inside {MULDIV_REM, MULDIV_REMU}) ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
      fin_value = neg_fin ? -div_sel : div_sel;
`else
      fin_value = '0;
`endif
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit, 32 radix-2 iterations per op
// Divide ops are implemented only when MULDIV_DIV_EN is defined; otherwise they return 0.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SEL_MULDIV_WIDTH-1:0] op,
  input  logic [XLEN-1:0]             src_a,
  input  logic [XLEN-1:0]             src_b,
  output logic                        busy,
  output logic                        done,
  output logic [XLEN-1:0]             result
);

  muldiv_state_e               state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [SEL_MULDIV_WIDTH-1:0] op_q, op_d;
  logic                        neg_q, neg_d;
  logic                        special_q, special_d;
  logic [XLEN-1:0]             mag_b_q, mag_b_d;
  logic [2*XLEN-1:0]           acc_q, acc_d;
  logic [XLEN-1:0]             result_q, result_d;

  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            res_neg;
  logic [XLEN-1:0] fin_value;
  logic [XLEN-1:0] fin_sel;
  logic [XLEN:0]   mul_sum;
`ifdef MULDIV_DIV_EN
  logic [XLEN:0]   div_shifted;
  logic [XLEN:0]   div_diff;
`endif

  muldiv_sign_adj #(.XLEN(XLEN)) u_sign_adj (
    .op_in     (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .res_neg   (res_neg),
    .op_fin    (op_q),
    .neg_fin   (neg_q),
    .acc       (acc_q),
    .fin_value (fin_value)
  );

  // Special-case divides park their final value in acc_q and skip sign fixup.
  assign fin_sel = special_q ? acc_q[XLEN-1:0] : fin_value;
  assign busy    = (state_q == ST_CALC);
  assign done    = (state_q == ST_FIN);
  assign result  = done ? fin_sel : result_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    special_d = special_q;
    mag_b_d   = mag_b_q;
    acc_d     = acc_q;
    result_d  = result_q;
    mul_sum   = '0;
`ifdef MULDIV_DIV_EN
    div_shifted = '0;
    div_diff    = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d      = op;
          neg_d     = res_neg;
          mag_b_d   = mag_b;
          cnt_d     = '0;
          special_d = 1'b0;
          // Multiplier in the low half; for divide the low half is the dividend.
          acc_d     = {{XLEN{1'b0}}, mag_a};
          state_d   = ST_CALC;
          if (is_div_op(op)) begin
`ifdef MULDIV_DIV_EN
            if (src_b == '0) begin
              special_d = 1'b1;
              acc_d     = {{XLEN{1'b0}}, (op[1] ? src_a : {XLEN{1'b1}})};
              state_d   = ST_FIN;
            end else if (!op[0] && src_a == {1'b1, {(XLEN-1){1'b0}}} && src_b == {XLEN{1'b1}}) begin
              special_d = 1'b1;
              acc_d     = {{XLEN{1'b0}}, (op[1] ? {XLEN{1'b0}} : src_a)};
              state_d   = ST_FIN;
            end
`else
            special_d = 1'b1;
            acc_d     = '0;
            state_d   = ST_FIN;
`endif
          end
        end
      end

      ST_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
`ifdef MULDIV_DIV_EN
        if (is_div_op(op_q)) begin
          div_shifted = acc_q[2*XLEN-1:XLEN-1];
          div_diff    = div_shifted - {1'b0, mag_b_q};
          if (!div_diff[XLEN]) begin
            acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = {div_shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
          end
        end else
`endif
        begin
          mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : {(XLEN+1){1'b0}});
          acc_d   = {mul_sum, acc_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_W'(XLEN-1)) begin
          state_d = ST_FIN;
        end
      end

      ST_FIN: begin
        result_d = fin_sel;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      mag_b_q   <= mag_b_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized and directed checks of mul_div_unit against an arithmetic model
// Divide expectations follow MULDIV_DIV_EN the same way the design build does.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    logic [63:0] p;
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
`ifdef MULDIV_DIV_EN
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  // Edges from the edge after which start is driven up to the one that opens the done cycle.
  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o < 3'd4) return 33;
`ifdef MULDIV_DIV_EN
    if (b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
`else
    return 1;
`endif
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int inject);
    logic [31:0] exp = model(o, a, b);
    int          lat = exp_lat(o, a, b);
    bit          seen = 0;
    bit          busy_ok = 1;
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clk); #1;
      start = (k == inject);
      op    = 3'($urandom);
      src_a = $urandom;
      src_b = $urandom;
      if (done) begin
        seen = 1;
        check_eq({tag, " latency"}, 32'(k), 32'(lat));
        check_eq({tag, " result"}, result, exp);
        check_eq({tag, " busy in done"}, 32'(busy), 32'd0);
      end else if (!busy) begin
        busy_ok = 0;
      end
    end
    start = 1'b0;
    check_eq({tag, " done seen"}, 32'(seen), 32'd1);
    check_eq({tag, " busy held"}, 32'(busy_ok), 32'd1);
    @(posedge clk); #1;
    check_eq({tag, " done pulse width"}, 32'(done), 32'd0);
    check_eq({tag, " result held"}, result, exp);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    check_eq("reset result", result, 32'd0);
    rst = 1'b0;

    run_op("mul 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op("mulh min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("mulhu max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulhsu -1*2", 3'd2, 32'hFFFF_FFFF, 32'd2, 0);
    run_op("div -20/3", 3'd4, 32'hFFFF_FFEC, 32'd3, 0);
    run_op("rem -20/3", 3'd6, 32'hFFFF_FFEC, 32'd3, 0);
    run_op("divu 20/3", 3'd5, 32'd20, 32'd3, 0);
    run_op("divu 5/0", 3'd5, 32'd5, 32'd0, 0);
    run_op("remu 5/0", 3'd7, 32'd5, 32'd0, 0);
    run_op("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Reset mid-calculation at counter 10 aborts without a done pulse.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; src_a = 32'd1234; src_b = 32'd5678;
    repeat (11) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort busy", 32'(busy), 32'd0);
    check_eq("abort done", 32'(done), 32'd0);
    check_eq("abort result", result, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check_eq("abort no done", 32'(seen), 32'd0);
    run_op("mul 3*4 after abort", 3'd0, 32'd3, 32'd4, 0);

    run_op("mul with start at cnt5", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 6);
    run_op("div with start at cnt5", 3'd4, 32'h8765_4321, 32'd77, 6);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  o = 3'($urandom_range(0, 7));
      logic [31:0] a = pick();
      logic [31:0] b = pick();
      int          inj = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : 0;
      run_op($sformatf("rand%0d op%0d", i, o), o, a, b, inj);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
